// File: rtl/la_pkg.sv
`default_nettype none
// ============================================================================
// Module : la_pkg
// Shared logic-analyser defaults and capture state encoding.
// Rev    : 1.0
// ============================================================================
package la_pkg;

    localparam int C_LA_WIDTH     = 8;
    localparam int C_LA_ADDR_BITS = 10;

    localparam logic [2:0] C_ST_IDLE = 3'd0;
    localparam logic [2:0] C_ST_PRE  = 3'd1;
    localparam logic [2:0] C_ST_WAIT = 3'd2;
    localparam logic [2:0] C_ST_POST = 3'd3;
    localparam logic [2:0] C_ST_DONE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = C_ST_IDLE,
        ST_PRE  = C_ST_PRE,
        ST_WAIT = C_ST_WAIT,
        ST_POST = C_ST_POST,
        ST_DONE = C_ST_DONE
    } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/trigger_match.sv
`default_nettype none
// ============================================================================
// Module : trigger_match
// Masked level/edge trigger compare on one probe sample.
// Rev    : 1.0
// ============================================================================
module trigger_match
    import la_pkg::*;
#(
    parameter int WIDTH = C_LA_WIDTH
) (
    input  logic [WIDTH-1:0] dat_in,
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] trig_mask,
    input  logic [WIDTH-1:0] trig_value,
    input  logic [WIDTH-1:0] trig_edge,
    output logic             match
);

    logic [WIDTH-1:0] w_level_ok;
    logic [WIDTH-1:0] w_edge_ok;

    assign w_level_ok = ~(dat_in ^ trig_value);
    // An edge bit is satisfied only if the previous sample was not yet at the target level
    assign w_edge_ok  = ~trig_edge | (prev ^ trig_value);
    assign match      = &(~trig_mask | (w_level_ok & w_edge_ok));

endmodule
`default_nettype wire

// File: rtl/capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module : capture_ctrl
// Pre/trigger/post sample capture into a circular RAM with masked trigger.
// Rev    : 1.0
// ============================================================================
module capture_ctrl
    import la_pkg::*;
#(
    parameter int WIDTH     = C_LA_WIDTH,
    parameter int ADDR_BITS = C_LA_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     dat_in,
    input  logic                 arm,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     trig_mask,
    input  logic [WIDTH-1:0]     trig_value,
    input  logic [WIDTH-1:0]     trig_edge,
    input  logic [ADDR_BITS-1:0] pre_count,
    input  logic [ADDR_BITS-1:0] post_count,
    output logic                 wr_en,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [WIDTH-1:0]     wr_data,
    output logic [ADDR_BITS-1:0] trig_addr,
    output logic                 busy,
    output logic                 triggered,
    output logic                 done
);

    localparam logic [ADDR_BITS-1:0] C_ONE = ADDR_BITS'(1);

    cap_state_t           r_state;
    cap_state_t           w_state_nxt;
    logic [ADDR_BITS-1:0] r_cnt;
    logic [ADDR_BITS-1:0] w_cnt_nxt;
    logic [ADDR_BITS-1:0] w_cnt_inc;
    logic [ADDR_BITS-1:0] r_pre;
    logic [ADDR_BITS-1:0] r_post;
    logic [WIDTH-1:0]     r_mask;
    logic [WIDTH-1:0]     r_value;
    logic [WIDTH-1:0]     r_edge;
    logic [WIDTH-1:0]     r_prev;
    logic [WIDTH-1:0]     r_wr_data;
    logic [ADDR_BITS-1:0] r_wr_addr;
    logic [ADDR_BITS-1:0] w_addr_nxt;
    logic [ADDR_BITS-1:0] r_trig_addr;
    logic                 r_wr_en;
    logic                 r_triggered;
    logic                 w_capture;
    logic                 w_arm_ok;
    logic                 w_match;
    logic                 w_trig_hit;

    trigger_match #(
        .WIDTH (WIDTH)
    ) u_trigger_match (
        .dat_in     (dat_in),
        .prev       (r_prev),
        .trig_mask  (r_mask),
        .trig_value (r_value),
        .trig_edge  (r_edge),
        .match      (w_match)
    );

    assign w_capture  = (r_state == ST_PRE) || (r_state == ST_WAIT) || (r_state == ST_POST);
    assign w_arm_ok   = arm && !abort && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_trig_hit = (r_state == ST_WAIT) && w_match && !abort;
    assign w_cnt_inc  = r_cnt + C_ONE;
    // Address the sample taken this cycle will be written to next cycle
    assign w_addr_nxt = r_wr_en ? (r_wr_addr + C_ONE) : r_wr_addr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_arm_ok) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = (pre_count != '0) ? ST_PRE : ST_WAIT;
                    end
                end
                ST_PRE: begin
                    if (w_cnt_inc == r_pre) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_WAIT;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                ST_WAIT: begin
                    if (w_match) begin
                        w_state_nxt = (r_post != '0) ? ST_POST : ST_DONE;
                    end
                end
                ST_POST: begin
                    if (w_cnt_inc == r_post) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_prev      <= '0;
            r_wr_en     <= 1'b0;
            r_wr_data   <= '0;
            r_wr_addr   <= '0;
            r_trig_addr <= '0;
            r_triggered <= 1'b0;
            r_mask      <= '0;
            r_value     <= '0;
            r_edge      <= '0;
            r_pre       <= '0;
            r_post      <= '0;
        end else begin
            r_prev  <= dat_in;
            r_wr_en <= w_capture && !abort;
            if (w_capture) begin
                r_wr_data <= dat_in;
            end
            if (w_arm_ok) begin
                r_wr_addr   <= '0;
                r_triggered <= 1'b0;
                r_mask      <= trig_mask;
                r_value     <= trig_value;
                r_edge      <= trig_edge;
                r_pre       <= pre_count;
                r_post      <= post_count;
            end else begin
                r_wr_addr <= w_addr_nxt;
                if (w_trig_hit) begin
                    r_trig_addr <= w_addr_nxt;
                    r_triggered <= 1'b1;
                end
            end
        end
    end

    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign trig_addr = r_trig_addr;
    assign triggered = r_triggered;
    assign busy      = w_capture;
    assign done      = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: doc/capture_ctrl.md
# capture_ctrl

Sample-clock-domain capture controller for the logic analyser. Consumes the synchronized probe bus produced by the synchronizer stage and evaluates a masked level/edge trigger. Streams samples into the circular sample RAM as pre-trigger history, trigger sample, then post-trigger samples. Reports the trigger address and completion to the readout logic.

## Interface
- WIDTH, 8, probe bus width (matches synchronizer WIDTH)
- ADDR_BITS, 10, sample RAM address width (depth 2^ADDR_BITS)

- clk  in  1  sample clock (same clock as the synchronizer capture side)
- reset_n  in  1  synchronous reset, active-low
- dat_in  in  WIDTH  synchronized probe samples, one per cycle
- arm  in  1  start capture; single-cycle pulse, honoured only in IDLE or DONE
- abort  in  1  cancel capture from any state
- trig_mask  in  WIDTH  1 = bit participates in trigger
- trig_value  in  WIDTH  required level per bit
- trig_edge  in  WIDTH  1 = bit additionally requires a transition into trig_value
- pre_count  in  ADDR_BITS  samples stored before trigger evaluation starts
- post_count  in  ADDR_BITS  samples stored after the trigger sample
- wr_en  out  1  RAM write strobe
- wr_addr  out  ADDR_BITS  RAM write address
- wr_data  out  WIDTH  RAM write data
- trig_addr  out  ADDR_BITS  address holding the trigger sample
- busy  out  1  high in PRE, WAIT, POST
- triggered  out  1  trigger seen in current or last capture
- done  out  1  capture complete; held until next arm or reset

## Operation
- States: IDLE, PRE, WAIT, POST, DONE.
- On accepted arm:
  - Latch trig_mask, trig_value, trig_edge, pre_count and post_count into shadow registers. Inputs may change freely afterwards.
  - Clear wr_addr, triggered, done and the sample counter.
  - Next state is PRE if pre_count ≠ 0, else WAIT.
- PRE: store every sample. After pre_count samples, go to WAIT.
- WAIT: store every sample and evaluate the trigger on each sample.
  - On a match, record that sample's address in trig_addr and set triggered.
  - Next state is POST if post_count ≠ 0, else DONE.
- POST: store post_count further samples, then go to DONE.
- Total stored samples = pre_count + 1 + post_count.
- Trigger match = AND over bits with trig_mask=1 of two terms:
  - Level term: dat_in[i] == trig_value[i].
  - Edge term, only where trig_edge[i]=1: prev[i] != trig_value[i].
- prev is dat_in registered every cycle regardless of state; reset value 0.
- All-zero mask matches the first WAIT sample.
- wr_addr increments after each write and wraps from 2^ADDR_BITS−1 to 0.
- Overflow is not an error. If pre_count+post_count+1 exceeds depth, the oldest samples are overwritten.
- abort: go to IDLE at the next edge.
  - No further writes.
  - done stays 0; triggered keeps its value.
  - arm and abort in the same cycle: abort wins.
- arm while busy is ignored.
- Reset (any state):
  - state IDLE; wr_en, wr_addr, wr_data, trig_addr, triggered, done, busy all 0; prev 0.

## Timing
- Capture latency is one cycle. dat_in sampled at the edge ending cycle t (state PRE/WAIT/POST in t) appears on wr_data/wr_addr with wr_en=1 in cycle t+1.
- Arm pulse in cycle 0 → capture state in cycle 1. The first stored sample is dat_in of cycle 1, written in cycle 2 at address 0.
- Trigger is evaluated on dat_in and prev in the same cycle the sample is taken. triggered and trig_addr update together with the trigger sample's wr_en cycle.
- The last sample's write occurs in the first DONE cycle. done and busy=0 are valid in that same cycle.
- Writes are back-to-back with no gaps from the first write to the last. wr_en is never asserted in IDLE except for the single trailing write after abort, which is suppressed.

## Structure
- Shared package la_pkg holds:
  - the state encoding localparams (IDLE, PRE, WAIT, POST, DONE, 3-bit);
  - common WIDTH/ADDR_BITS defaults used with the synchronizer and RAM.
- One sub-module: trigger_match.
  - Combinational mask/value/edge compare.
  - Inputs: dat_in, prev and the shadow config. Output: single bit match.
- Counters, state machine and write port live in capture_ctrl.

## Test plan
- WIDTH=8, ADDR_BITS=4. Stimulus: pre_count=3, post_count=2, mask=0x01, value=0x01, edge=0; dat_in counts 0x10, 0x11, … from cycle 1. Required:
  - samples 0x10–0x12 at addresses 0–2;
  - 0x13 (first odd in WAIT) at address 3, trig_addr=3;
  - 0x14 and 0x15 at addresses 4–5;
  - done in cycle 7.
- Edge trigger: mask=0x80, value=0x80, edge=0x80, dat_in held at 0x80 through WAIT, then 0x00, then 0x80. Required: the trigger occurs only on the second 0x80, never on the held level.
- Wrap: pre_count=14, post_count=5, mask=0. Required:
  - 20 writes with addresses 0…15, 0…3;
  - trig_addr=14; done after the write to address 3.
- abort during POST (second post sample). Required:
  - no wr_en from the next cycle on; state IDLE; done=0; triggered=1.
  - A new arm then restarts at address 0.
- arm while busy and arm+abort simultaneously. Required:
  - the first is ignored and wr_addr keeps counting;
  - the second goes to IDLE with no write.
- reset_n low for one cycle in WAIT. Required: all outputs 0 next cycle, and no write until a new arm.
